// File: rtl/lifo_stack_pkg.sv
// Shared defaults and sizing helpers for the lifo_stack block.
package lifo_stack_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;
    localparam int TICK_W_DEF = 25;

    // Occupancy runs 0..depth inclusive, so it needs one more code than an index.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lifo_tick_gen.sv
// Free-running divider for the board demo build (LIFO_STACK_TICK_EN):
// ce pulses once every 2^TICK_W clocks, led shows the divider MSB.
module lifo_tick_gen
    import lifo_stack_pkg::*;
#(
    parameter int TICK_W = TICK_W_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic ce,
    output logic led
);

    logic [TICK_W-1:0] tick_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign ce  = &tick_cnt;
    assign led = tick_cnt[TICK_W-1];

endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with registered read port, occupancy and
// overflow/underflow pulses. Define LIFO_STACK_TICK_EN for the slow-tick demo build.
module lifo_stack
    import lifo_stack_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int TICK_W = TICK_W_DEF,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow,
    output logic              led
);

    localparam int ADDR_W = $clog2(DEPTH);

    if (DEPTH < 2 || TICK_W < 1) begin : g_param_check
        $error("lifo_stack: DEPTH must be >= 2 and TICK_W >= 1");
    end

    logic ce;

`ifdef LIFO_STACK_TICK_EN
    lifo_tick_gen #(
        .TICK_W (TICK_W)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .led (led)
    );
`else
    assign ce  = 1'b1;
    assign led = 1'b0;
`endif

    logic              eff_push;
    logic              eff_pop;
    logic [ADDR_W-1:0] push_idx;
    logic [ADDR_W-1:0] top_idx;
    logic [ADDR_W-1:0] wr_idx;
    logic              wr_en;

    logic [DATA_W-1:0] mem [DEPTH];

    assign eff_push = push & ce;
    assign eff_pop  = pop & ce;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    assign push_idx = ADDR_W'(count);
    assign top_idx  = ADDR_W'(count - 1'b1);

    // A simultaneous push+pop on a non-empty stack overwrites the top in place;
    // on an empty stack it degenerates to a plain push into slot 0.
    assign wr_en  = !rst && eff_push && (eff_pop ? 1'b1 : !full);
    assign wr_idx = (eff_pop && !empty) ? top_idx : push_idx;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            case ({eff_push, eff_pop})
                2'b10: begin
                    if (full) begin
                        overflow <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                2'b01: begin
                    if (empty) begin
                        underflow <= 1'b1;
                    end else begin
                        dout       <= mem[top_idx];
                        dout_valid <= 1'b1;
                        count      <= count - 1'b1;
                    end
                end
                2'b11: begin
                    if (empty) begin
                        underflow <= 1'b1;
                        count     <= CNT_W'(1);
                    end else begin
                        dout       <= mem[top_idx];
                        dout_valid <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Parametrised LIFO stack, the next generation of the team's 4-bit/16-entry push-pop stack.
- Separate push and pop strobes replace the single rw line.
- Adds a registered read port with a valid flag, an occupancy count, overflow/underflow pulses, and push+pop replace-top.
- Sits between a user-facing input block (switches/buttons or upstream logic) and display/consumer logic.
- An optional on-board slow tick makes it usable as a board demo.

Parameters:
- DATA_W, 8, width of each stored word.
- DEPTH, 16, number of entries; must be >= 2. All DEPTH entries are usable.
- TICK_W, 25, divider counter width, used only with the optional feature. Tick period is 2^TICK_W clk cycles.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  write din onto the stack this cycle (qualified by tick when the feature is on).
- pop  in  1  remove the top entry this cycle.
- din  in  DATA_W  data to push.
- dout  out  DATA_W  last popped word, registered.
- dout_valid  out  1  one-cycle pulse: dout was updated by a pop.
- count  out  CNT_W  occupancy, 0..DEPTH; CNT_W = clog2(DEPTH+1).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  one-cycle pulse: push refused because the stack was full.
- underflow  out  1  one-cycle pulse: pop refused because the stack was empty.
- led  out  1  divider MSB when the feature is on; constant 0 otherwise.

Behaviour:
- Reset (rst=1 at a clk edge, takes priority over everything):
  - count=0, dout=0, dout_valid=0, overflow=0, underflow=0, empty=1, full=0, led=0.
  - Memory contents are not cleared.
  - Reset asserted mid-sequence discards the stack immediately; the next cycle behaves as empty.
- Effective strobes: eff_push = push & ce and eff_pop = pop & ce.
  - ce=1 always, unless the optional feature is on.
- Storage: mem[0..DEPTH-1]; top entry at mem[count-1]. full and empty are derived combinationally from count.
- Cases, evaluated per cycle on the registered state:
  - eff_push only, not full: mem[count] <= din; count+1.
  - eff_push only, full: no write; count unchanged; overflow pulses 1 cycle.
  - eff_pop only, not empty: dout <= mem[count-1]; dout_valid pulses; count-1. One-cycle latency from pop to dout/dout_valid.
  - eff_pop only, empty: dout holds; dout_valid=0; underflow pulses.
  - eff_push & eff_pop, not empty (including full): replace top.
    - dout <= old mem[count-1]; dout_valid pulses; mem[count-1] <= din.
    - count unchanged; no overflow, even when full.
  - eff_push & eff_pop, empty: push is performed (mem[0] <= din, count=1); underflow pulses; dout_valid=0.
  - Neither: all state holds; pulse outputs return to 0.
- Pushes and pops never wrap around: count saturates at 0 and DEPTH.
- Arithmetic is on CNT_W bits; the index uses the low clog2(DEPTH) bits of count or count-1.
- Memory writes are synchronous. The read of mem[count-1] happens in the same edge as the pop, so no read-before-write hazard exists within a single port.

Optional Feature:
- LIFO_STACK_TICK_EN defined:
  - A free-running TICK_W-bit counter, cleared by rst, generates ce as a single-cycle pulse when the counter equals all-ones.
  - push and pop are sampled only on ce cycles; pulse outputs last one clk cycle.
  - led = counter MSB.
- Not defined: ce tied 1, no counter is instantiated, led=0.

Decomposition:
- Package lifo_stack_pkg:
  - default constants DATA_W_DEF=8, DEPTH_DEF=16, TICK_W_DEF=25;
  - a cnt_width(depth) function returning clog2(depth+1).
- One natural sub-module: lifo_tick_gen (TICK_W counter, ce pulse, led), instantiated only under LIFO_STACK_TICK_EN.

Test Plan:
- After reset, push 0x11,0x22,0x33 on consecutive cycles -> count=3, empty=0. Then pop x3 -> dout 0x33,0x22,0x11 each one cycle after its pop, dout_valid high on each; final count=0, empty=1.
- Push 16 words 0x00..0x0F, then push 0xAA -> full=1 after the 16th push; overflow pulses on the 17th; count stays 16. The next pop returns 0x0F.
- Pop on an empty stack -> underflow pulses 1 cycle, dout_valid=0, dout unchanged, count=0.
- Stack holds 0x05,0x07; push 0x09 and pop in the same cycle -> dout=0x07 and dout_valid=1; count stays 2. The next pop returns 0x09.
- With count=5, assert rst for 1 cycle alongside push -> count=0, empty=1, no pulses. The next pop gives underflow.
- With LIFO_STACK_TICK_EN and TICK_W=3, hold push high with din=0x3C for 16 clk -> exactly 2 pushes accepted (count=2); led toggles every 4 clk.
